// File: rtl/psg_tone_noise_gen_pkg.sv
// Shared widths, LFSR constants and the LFSR next-state helper for the PSG tone/noise block.
// No logic; no latency; no flow control.
// Imported by the tone counter and the top.
package psg_pkg;

    localparam int TONE_W    = 12;
    localparam int NOISE_W   = 5;
    localparam int LFSR_W    = 17;
    localparam int LFSR_TAP0 = 0;
    localparam int LFSR_TAP1 = 3;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h00001;

    // All-zero is a lock-up state for an XOR LFSR, so it reseeds instead of shifting.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        if (s == '0) begin
            return LFSR_SEED;
        end
        return {s[LFSR_TAP0] ^ s[LFSR_TAP1], s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/psg_tone_noise_gen_tone_counter.sv
// Half-period counter: toggles sq and flags wrap when count+1 reaches max(period,1).
// Latency: sq changes on the edge that samples the step; wrap is combinational in the step cycle.
// No backpressure: steps are never stalled, idle cycles hold state.
module psg_tone_counter
    import psg_pkg::*;
#(
    parameter int W = TONE_W
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         step,
    input  logic [W-1:0] period,
    output logic         sq,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;
    logic [W-1:0] eff_period;
    logic [W:0]   cnt_inc;

    // The compare is one bit wider so a period lowered below the count wraps immediately
    // rather than counting on through the top of the range.
    always_comb begin
        eff_period = (period == '0) ? ONE : period;
        cnt_inc    = {1'b0, cnt} + {1'b0, ONE};
        wrap       = step && (cnt_inc >= {1'b0, eff_period});
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (step) begin
            if (wrap) begin
                cnt <= '0;
                sq  <= ~sq;
            end else begin
                cnt <= cnt_inc[W-1:0];
            end
        end
    end

endmodule

// File: rtl/psg_tone_noise_gen.sv
// Three square-wave tone channels plus LFSR noise, stepped from a prescaled clk_en.
// Latency: outputs and step_stb update one clk_in after the terminal clk_en pulse.
// No backpressure: clk_en=0 cycles freeze all state.
module psg_tone_noise_gen
    import psg_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clk_en,
    input  logic [TONE_W-1:0] tone_period_a,
    input  logic [TONE_W-1:0] tone_period_b,
    input  logic [TONE_W-1:0] tone_period_c,
    input  logic [NOISE_W-1:0] noise_period,
    output logic              tone_a,
    output logic              tone_b,
    output logic              tone_c,
    output logic              noise,
    output logic              step_stb
);

    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    logic [7:0]        prescale_cnt;
    logic              step;
    logic              noise_tgl;
    logic              noise_step;
    logic              noise_wrap;
    logic              noise_half_unused;
    logic [LFSR_W-1:0] lfsr;
    logic              tone_a_wrap_unused;
    logic              tone_b_wrap_unused;
    logic              tone_c_wrap_unused;

    assign step       = clk_en && (prescale_cnt == PRE_LAST);
    assign noise_step = step && noise_tgl;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            prescale_cnt <= '0;
            step_stb     <= 1'b0;
            noise_tgl    <= 1'b0;
        end else begin
            step_stb <= step;
            if (clk_en) begin
                prescale_cnt <= (prescale_cnt == PRE_LAST) ? 8'd0 : prescale_cnt + 8'd1;
            end
            if (step) begin
                noise_tgl <= ~noise_tgl;
            end
        end
    end

    psg_tone_counter #(.W(TONE_W)) u_tone_a (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .step   (step),
        .period (tone_period_a),
        .sq     (tone_a),
        .wrap   (tone_a_wrap_unused)
    );

    psg_tone_counter #(.W(TONE_W)) u_tone_b (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .step   (step),
        .period (tone_period_b),
        .sq     (tone_b),
        .wrap   (tone_b_wrap_unused)
    );

    psg_tone_counter #(.W(TONE_W)) u_tone_c (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .step   (step),
        .period (tone_period_c),
        .sq     (tone_c),
        .wrap   (tone_c_wrap_unused)
    );

    // Noise uses the same half-period rule; only its wrap strobe matters here.
    psg_tone_counter #(.W(NOISE_W)) u_noise_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .step   (noise_step),
        .period (noise_period),
        .sq     (noise_half_unused),
        .wrap   (noise_wrap)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lfsr  <= LFSR_SEED;
            noise <= 1'b0;
        end else if (noise_wrap) begin
            lfsr  <= lfsr_next(lfsr);
            noise <= lfsr_next(lfsr)[0];
        end
    end

endmodule

// File: tb/tb_psg_tone_noise_gen.sv
// Directed bench: table of period settings with hand-computed tone levels, plus timing,
// noise, async reset and freeze sequences.
module tb_psg_tone_noise_gen;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        clk_en = 1'b0;
    logic [11:0] tone_period_a = '0;
    logic [11:0] tone_period_b = '0;
    logic [11:0] tone_period_c = '0;
    logic [4:0]  noise_period = '0;
    logic        tone_a, tone_b, tone_c, noise, step_stb;

    int checks = 0;
    int errors = 0;

    psg_tone_noise_gen #(.PRESCALE(8)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .clk_en        (clk_en),
        .tone_period_a (tone_period_a),
        .tone_period_b (tone_period_b),
        .tone_period_c (tone_period_c),
        .noise_period  (noise_period),
        .tone_a        (tone_a),
        .tone_b        (tone_b),
        .tone_c        (tone_c),
        .noise         (noise),
        .step_stb      (step_stb)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [11:0] pa;
        logic [11:0] pb;
        logic [11:0] pc;
        int          n_steps;
        logic        exp_a;
        logic        exp_b;
        logic        exp_c;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at posedge+1 with reset released and clk_en low.
    task automatic do_reset();
        clk_en = 1'b0;
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // One clk_en pulse followed by gap-1 idle cycles; returns at posedge+1.
    task automatic en_pulse(input int gap);
        clk_en = 1'b1;
        @(posedge clk_in);
        #1;
        clk_en = 1'b0;
        for (int g = 1; g < gap; g++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_step();
        repeat (8) en_pulse(1);
    endtask

    initial begin
        // periods a/b/c, steps from reset, expected tone levels: level = parity of n/max(p,1)
        vecs[0] = '{12'd1,    12'd0,  12'd3, 5,  1'b1, 1'b1, 1'b1};
        vecs[1] = '{12'd2,    12'd1,  12'd3, 6,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{12'd4,    12'd7,  12'd0, 7,  1'b1, 1'b1, 1'b1};
        vecs[3] = '{12'd5,    12'd3,  12'd2, 10, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{12'd4095, 12'd12, 12'd1, 12, 1'b0, 1'b1, 1'b0};

        // Reset state while rst_in is held
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_outputs", {27'd0, tone_a, tone_b, tone_c, noise, step_stb}, 32'd0);
        rst_in = 1'b0;

        // Table-driven tone levels
        for (int v = 0; v < 5; v++) begin
            tone_period_a = vecs[v].pa;
            tone_period_b = vecs[v].pb;
            tone_period_c = vecs[v].pc;
            do_reset();
            repeat (vecs[v].n_steps) do_step();
            check($sformatf("vec%0d_tone_a", v), {31'd0, tone_a}, {31'd0, vecs[v].exp_a});
            check($sformatf("vec%0d_tone_b", v), {31'd0, tone_b}, {31'd0, vecs[v].exp_b});
            check($sformatf("vec%0d_tone_c", v), {31'd0, tone_c}, {31'd0, vecs[v].exp_c});
        end

        // clk_en every 4th cycle: step_stb and tone_a toggles 32 cycles apart
        begin
            int stb_cyc[$];
            int tgl_cyc[$];
            logic prev_a;
            tone_period_a = 12'd1;
            do_reset();
            prev_a = tone_a;
            for (int i = 0; i < 200; i++) begin
                clk_en = (i % 4 == 3);
                @(posedge clk_in);
                #1;
                if (step_stb) stb_cyc.push_back(i);
                if (tone_a != prev_a) tgl_cyc.push_back(i);
                prev_a = tone_a;
            end
            clk_en = 1'b0;
            check("s1_stb_count", stb_cyc.size(), 6);
            check("s1_tgl_count", tgl_cyc.size(), 6);
            if (stb_cyc.size() >= 2) begin
                check("s1_first_stb", stb_cyc[0], 31);
                check("s1_stb_gap", stb_cyc[1] - stb_cyc[0], 32);
            end else begin
                check("s1_stb_seen", stb_cyc.size(), 2);
            end
            if (tgl_cyc.size() >= 2) begin
                check("s1_tgl_gap", tgl_cyc[1] - tgl_cyc[0], 32);
            end else begin
                check("s1_tgl_seen", tgl_cyc.size(), 2);
            end
        end

        // Period lowered below the running count wraps on the next step
        tone_period_a = 12'd100;
        do_reset();
        repeat (50) do_step();
        check("s3_before", {31'd0, tone_a}, 32'd0);
        tone_period_a = 12'd5;
        do_step();
        check("s3_wrap_now", {31'd0, tone_a}, 32'd1);
        repeat (4) do_step();
        check("s3_hold4", {31'd0, tone_a}, 32'd1);
        do_step();
        check("s3_next5", {31'd0, tone_a}, 32'd0);

        // Noise against a reference LFSR, noise_period=1
        begin
            logic [16:0] m;
            int bad;
            m = 17'h00001;
            bad = 0;
            noise_period = 5'd1;
            do_reset();
            for (int k = 0; k < 20; k++) do_step();
            do_reset();
            for (int k = 0; k < 20; k++) begin
                do_step();
                do_step();
                m = {m[0] ^ m[3], m[16:1]};
                if (noise !== m[0]) bad++;
            end
            check("s4_noise_seq", bad, 0);
            check("s4_noise_last", {31'd0, noise}, {31'd0, m[0]});
        end

        // Async reset between edges, then exactly 8 clk_en pulses to the first step
        begin
            int first;
            tone_period_a = 12'd1;
            do_reset();
            do_step();
            check("s5_pre_tone_a", {31'd0, tone_a}, 32'd1);
            repeat (3) en_pulse(1);
            #3;
            rst_in = 1'b1;
            #1;
            check("s5_async_zero", {27'd0, tone_a, tone_b, tone_c, noise, step_stb}, 32'd0);
            @(posedge clk_in);
            #1;
            rst_in = 1'b0;
            first = 0;
            for (int p = 1; p <= 20 && first == 0; p++) begin
                en_pulse(1);
                if (step_stb) first = p;
            end
            check("s5_first_step", first, 8);
        end

        // clk_en low for 1000 cycles freezes everything
        begin
            int bad;
            bad = 0;
            tone_period_a = 12'd1;
            do_reset();
            do_step();
            repeat (3) en_pulse(1);
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk_in);
                #1;
                if (tone_a !== 1'b1 || step_stb !== 1'b0 || noise !== 1'b0) bad++;
            end
            check("s6_frozen", bad, 0);
            repeat (4) en_pulse(1);
            check("s6_no_early", {31'd0, step_stb}, 32'd0);
            en_pulse(1);
            check("s6_resume_stb", {31'd0, step_stb}, 32'd1);
            check("s6_resume_tone", {31'd0, tone_a}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
